// File: rtl/neuron_pkg.sv
// Shared widths and saturating arithmetic helpers for the neuron MAC datapath.
// Helpers work on a 64-bit carrier and clamp to any signed width up to 64.
package neuron_pkg;

  localparam int NUM_WEIGHT_DEF    = 784;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int FRAC_BITS_DEF     = 8;
  localparam int SIG_IN_WIDTH_DEF  = 10;
  localparam int SIG_FRAC_BITS_DEF = 5;
  localparam int ACC_WIDTH         = 2 * DATA_WIDTH_DEF;

  localparam int SAT_MAXW = 64;
  typedef logic signed [SAT_MAXW-1:0] sat_t;
  typedef logic signed [SAT_MAXW:0]   sat_wide_t;

  // Clamp a signed value into the signed range of out_width bits.
  function automatic sat_t sat_trunc(input sat_wide_t value, input int out_width);
    sat_wide_t one;
    sat_wide_t hi;
    sat_wide_t lo;
    one = sat_wide_t'(1);
    hi  = (one <<< (out_width - 1)) - one;
    lo  = -hi - one;
    if (value > hi) begin
      return sat_t'(hi);
    end else if (value < lo) begin
      return sat_t'(lo);
    end
    return sat_t'(value);
  endfunction

  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int width);
    sat_wide_t sum;
    sum = sat_wide_t'(a) + sat_wide_t'(b);
    return sat_trunc(sum, width);
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Activation stream, weight-load port and sigmoid-address result of one neuron MAC.
interface neuron_mac_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int SIG_IN_WIDTH = 10
);
  logic                           in_valid;
  logic signed [DATA_WIDTH-1:0]   in_data;
  logic signed [DATA_WIDTH-1:0]   bias;
  logic                           w_wr_en;
  logic        [ADDR_WIDTH-1:0]   w_addr;
  logic signed [DATA_WIDTH-1:0]   w_data;
  logic                           out_valid;
  logic signed [SIG_IN_WIDTH-1:0] sig_x;

  modport master (
    output in_valid, in_data, bias, w_wr_en, w_addr, w_data,
    input  out_valid, sig_x
  );

  modport slave (
    input  in_valid, in_data, bias, w_wr_en, w_addr, w_data,
    output out_valid, sig_x
  );
endinterface

// File: rtl/neuron_mac_weight_mem.sv
// Simple dual-port weight RAM: one synchronous write port, one registered read port.
// Latency: read data valid one cycle after rd_en_i; contents are never reset.
// No backpressure: every write and read is accepted in the cycle presented.
module weight_mem #(
    parameter int    DEPTH       = 784,
    parameter int    WIDTH       = 16,
    parameter int    ADDR_WIDTH  = 10,
    parameter string WEIGHT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_dat_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_dat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate feeding the sigmoid ROM; result pulse 3 cycles after the last input.
// No backpressure: one element per cycle in, every result pulse must be consumed downstream.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int    NUM_WEIGHT    = NUM_WEIGHT_DEF,
  parameter int    DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int    FRAC_BITS     = FRAC_BITS_DEF,
  parameter int    SIG_IN_WIDTH  = SIG_IN_WIDTH_DEF,
  parameter int    SIG_FRAC_BITS = SIG_FRAC_BITS_DEF,
  parameter int    ADDR_WIDTH    = $clog2(NUM_WEIGHT),
  parameter string WEIGHT_FILE   = ""
) (
  input logic         clk,
  input logic         rst_n,
  neuron_mac_if.slave bus
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int SHIFT = 2 * FRAC_BITS - SIG_FRAC_BITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WEIGHT - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_W_EXT = (ADDR_WIDTH + 1)'(NUM_WEIGHT);

  logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
  logic                           s0_vld_q, s0_last_q;
  logic signed [DATA_WIDTH-1:0]   s0_dat_q;
  logic signed [DATA_WIDTH-1:0]   w_rd;
  logic                           s1_vld_q, s1_last_q;
  logic signed [ACC_W-1:0]        prod_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic                           out_vld_q;
  logic signed [SIG_IN_WIDTH-1:0] sig_q;

  logic idle;
  logic wr_ok;
  sat_t sum_acc, bias_x, sum_b, shifted, sig_full;

  assign idle  = (cnt_q == '0) && !s0_vld_q && !s1_vld_q;
  assign wr_ok = bus.w_wr_en && idle && ({1'b0, bus.w_addr} < NUM_W_EXT);

  weight_mem #(
    .DEPTH      (NUM_WEIGHT),
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WEIGHT_FILE(WEIGHT_FILE)
  ) u_weight_mem (
    .clk      (clk),
    .wr_en_i  (wr_ok),
    .wr_addr_i(bus.w_addr),
    .wr_dat_i (bus.w_data),
    .rd_en_i  (bus.in_valid),
    .rd_addr_i(cnt_q),
    .rd_dat_o (w_rd)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Bias is Q(FRAC_BITS); aligning it to the Q(2*FRAC_BITS) product domain.
  always_comb begin
    sum_acc  = sat_add(sat_t'(acc_q), sat_t'(prod_q), ACC_W);
    bias_x   = sat_t'(bus.bias) <<< FRAC_BITS;
    sum_b    = sat_add(sum_acc, bias_x, ACC_W);
    shifted  = sum_b >>> SHIFT;
    sig_full = sat_trunc(sat_wide_t'(shifted), SIG_IN_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      s0_vld_q  <= 1'b0;
      s0_last_q <= 1'b0;
      s0_dat_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      sig_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      s0_vld_q  <= bus.in_valid;
      s0_last_q <= bus.in_valid && (cnt_q == LAST_IDX);
      s0_dat_q  <= bus.in_data;
      s1_vld_q  <= s0_vld_q;
      s1_last_q <= s0_last_q;
      prod_q    <= ACC_W'(s0_dat_q) * ACC_W'(w_rd);
      out_vld_q <= 1'b0;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          sig_q     <= sig_full[SIG_IN_WIDTH-1:0];
          out_vld_q <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= sum_acc[ACC_W-1:0];
        end
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.sig_x     = sig_q;

endmodule
